bm_datapath_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 2-bit operand datapath among NREQ requesters. Each requester presents an operand pair. The block grants one requester, issues its operands to the shared unit, and waits a fixed latency. It then returns the captured result tagged with the requester id. It sits between the microbenchmark requester logic and the shared case-decode/AND datapath unit.

---
 rtl/bm_datapath_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_bm_datapath_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_datapath_rr_arbiter.sv
// Round-robin arbiter that issues one requester's operands to a shared fixed-latency
// datapath, waits for its result and returns it tagged with the requester id.
module bm_datapath_rr_arbiter #(
    parameter int BITS = 2,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] a_bus,
    input  logic [NREQ*BITS-1:0] b_bus,
    output logic [NREQ-1:0]      gnt,
    output logic [BITS-1:0]      dp_a,
    output logic [BITS-1:0]      dp_b,
    output logic                 dp_valid,
    input  logic [BITS-1:0]      dp_result,
    output logic [BITS-1:0]      result,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic                 busy
);

    localparam int CNTW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [IDW-1:0]  last, last_nxt;
    logic [IDW-1:0]  cur_id, cur_id_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [BITS-1:0] dp_a_nxt, dp_b_nxt, result_nxt;
    logic            dp_valid_nxt, done_nxt;
    logic [IDW-1:0]  done_id_nxt;

    logic            found;
    logic [IDW-1:0]  winner;

    // Rotating-priority search: start just after the last completed requester.
    always_comb begin
        int             idx;
        logic [IDW-1:0] pos;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        pos    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(last) + 1 + i) % NREQ;
            pos = IDW'(idx);
            if (!found && req[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_nxt     = last;
        cur_id_nxt   = cur_id;
        gnt_nxt      = '0;
        dp_valid_nxt = 1'b0;
        dp_a_nxt     = dp_a;
        dp_b_nxt     = dp_b;
        result_nxt   = result;
        done_nxt     = 1'b0;
        done_id_nxt  = done_id;

        case (state)
            IDLE: begin
                if (found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (winner == IDW'(i)) begin
                            gnt_nxt[i] = 1'b1;
                            dp_a_nxt   = a_bus[i*BITS +: BITS];
                            dp_b_nxt   = b_bus[i*BITS +: BITS];
                        end
                    end
                    dp_valid_nxt = 1'b1;
                    cur_id_nxt   = winner;
                    cnt_nxt      = CNTW'(LAT);
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                // The datapath samples the issue one edge after the grant, so the
                // result is ready once LAT further edges have elapsed.
                if (cnt == '0) begin
                    result_nxt  = dp_result;
                    done_nxt    = 1'b1;
                    done_id_nxt = cur_id;
                    last_nxt    = cur_id;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            last     <= IDW'(NREQ - 1);
            cur_id   <= '0;
            gnt      <= '0;
            dp_valid <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
            result   <= '0;
            done     <= 1'b0;
            done_id  <= '0;
        end else begin
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            cur_id   <= cur_id_nxt;
            gnt      <= gnt_nxt;
            dp_valid <= dp_valid_nxt;
            dp_a     <= dp_a_nxt;
            dp_b     <= dp_b_nxt;
            result   <= result_nxt;
            done     <= done_nxt;
            done_id  <= done_id_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bm_datapath_rr_arbiter.sv
// Directed bench for bm_datapath_rr_arbiter: a LAT=2 instance for the main sequence
// and a LAT=1 instance for the short-latency timing.
module tb_bm_datapath_rr_arbiter;

    logic       clock;
    logic       reset;

    logic [3:0] req, gnt;
    logic [7:0] a_bus, b_bus;
    logic [1:0] dp_a, dp_b, dp_result, result, done_id;
    logic       dp_valid, done, busy;

    logic [3:0] req1, gnt1;
    logic [7:0] a_bus1, b_bus1;
    logic [1:0] dp_a1, dp_b1, dp_result1, result1, done_id1;
    logic       dp_valid1, done1, busy1;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;

    bm_datapath_rr_arbiter #(.BITS(2), .NREQ(4), .IDW(2), .LAT(2)) u_dut (
        .clock(clock), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .dp_a(dp_a), .dp_b(dp_b), .dp_valid(dp_valid),
        .dp_result(dp_result), .result(result), .done(done), .done_id(done_id),
        .busy(busy)
    );

    bm_datapath_rr_arbiter #(.BITS(2), .NREQ(4), .IDW(2), .LAT(1)) u_dut_lat1 (
        .clock(clock), .reset(reset), .req(req1), .a_bus(a_bus1), .b_bus(b_bus1),
        .gnt(gnt1), .dp_a(dp_a1), .dp_b(dp_b1), .dp_valid(dp_valid1),
        .dp_result(dp_result1), .result(result1), .done(done1), .done_id(done_id1),
        .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared-unit model: low two bits of a*b, delivered LAT edges after the issue is sampled.
    function automatic logic [1:0] dp_func(input logic [1:0] a, input logic [1:0] b);
        logic [3:0] p;
        p = a * b;
        return p[1:0];
    endfunction

    logic [1:0] m0_s1, m0_s2, m1_s1;
    always_ff @(posedge clock) begin
        m0_s1 <= dp_valid ? dp_func(dp_a, dp_b) : 2'b00;
        m0_s2 <= m0_s1;
        m1_s1 <= dp_valid1 ? dp_func(dp_a1, dp_b1) : 2'b00;
    end
    assign dp_result  = m0_s2;
    assign dp_result1 = m1_s1;

    always @(negedge clock) begin
        if ((done && gnt != 4'b0) || (done1 && gnt1 != 4'b0)) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_gnt(input bit sel, output int id, output int cyc);
        logic [3:0] g;
        id  = -1;
        cyc = 0;
        g   = 4'b0;
        while (cyc < 20 && g == 4'b0) begin
            tick();
            cyc++;
            g = sel ? gnt1 : gnt;
        end
        if (g == 4'b0) begin
            check("gnt_timeout", 32'd1, 32'd0);
        end else begin
            check("gnt_onehot", 32'($onehot(g)), 32'd1);
            for (int j = 0; j < 4; j++) if (g[j]) id = j;
        end
    endtask

    task automatic wait_done(input bit sel);
        int  cyc;
        logic d;
        cyc = 0;
        d   = 1'b0;
        while (cyc < 20 && !d) begin
            tick();
            cyc++;
            d = sel ? done1 : done;
        end
        if (!d) check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int id, cyc, bc;
        logic seen_done;
        logic [1:0] exp_a [0:4];

        reset = 1'b1;
        req = 4'b0; a_bus = 8'b0; b_bus = 8'b0;
        req1 = 4'b0; a_bus1 = 8'b0; b_bus1 = 8'b0;
        tick();
        tick();
        check("rst_gnt", gnt, 4'b0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dp_valid", dp_valid, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        tick();

        // Single request, latency 2
        a_bus[1:0] = 2'b01; b_bus[1:0] = 2'b10; req = 4'b0001;
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_dp_valid", dp_valid, 1);
        check("t1_dp_a", dp_a, 2'b01);
        check("t1_dp_b", dp_b, 2'b10);
        bc = busy;
        req = 4'b0;
        tick();
        check("t1_gnt_low", gnt, 4'b0);
        check("t1_dp_valid_low", dp_valid, 0);
        bc += busy;
        tick();
        check("t1_done_early", done, 0);
        bc += busy;
        tick();
        check("t1_done", done, 1);
        check("t1_done_id", done_id, 0);
        check("t1_result", result, 2'b10);
        bc += busy;
        tick();
        check("t1_done_low", done, 0);
        check("t1_idle", busy, 0);
        check("t1_busy_cycles", bc, 4);

        // Full contention from reset: order 0,1,2,3,0 every 5 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_bus = 8'b11100100;
        b_bus = 8'b00011011;
        exp_a[0] = 2'd0; exp_a[1] = 2'd1; exp_a[2] = 2'd2; exp_a[3] = 2'd3; exp_a[4] = 2'd0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(1'b0, id, cyc);
            check("t2_order", id, k % 4);
            check("t2_dp_a", dp_a, exp_a[k]);
            if (k > 0) check("t2_spacing", cyc, 5);
        end
        req = 4'b0;
        wait_done(1'b0);
        check("t2_done_id", done_id, 0);
        check("t2_result", result, 2'd0);

        // Rotation skip: after 2 completes, 3 beats 1
        req = 4'b0100;
        wait_gnt(1'b0, id, cyc);
        check("t3_first", id, 2);
        req = 4'b0;
        wait_done(1'b0);
        check("t3_done_id", done_id, 2);
        req = 4'b1010;
        wait_gnt(1'b0, id, cyc);
        check("t3_skip", id, 3);
        req = 4'b0010;
        wait_done(1'b0);
        wait_gnt(1'b0, id, cyc);
        check("t3_then", id, 1);
        req = 4'b0;
        wait_done(1'b0);
        check("t3_result", result, 2'd2);

        // Reset mid-WAIT: outputs clear asynchronously, no done, rotation restarts at 0
        a_bus[1:0] = 2'b11;
        req = 4'b0001;
        wait_gnt(1'b0, id, cyc);
        check("t4_gnt", id, 0);
        req = 4'b0;
        tick();
        check("t4_waiting", busy, 1);
        reset = 1'b1;
        #1;
        check("t4_async_busy", busy, 0);
        check("t4_async_dp_a", dp_a, 2'b00);
        check("t4_async_gnt", gnt, 4'b0);
        tick();
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen_done |= done;
        end
        check("t4_no_done", seen_done, 0);
        req = 4'b1001;
        wait_gnt(1'b0, id, cyc);
        check("t4_last_reset", id, 0);
        req = 4'b0;
        wait_done(1'b0);
        req = 4'b1000;
        wait_gnt(1'b0, id, cyc);
        check("t4_req3", id, 3);
        req = 4'b0;
        wait_done(1'b0);
        check("t4_done_id", done_id, 3);

        // Operand stability
        a_bus[5:4] = 2'b11; b_bus[5:4] = 2'b11;
        req = 4'b0100;
        wait_gnt(1'b0, id, cyc);
        check("t5_gnt", id, 2);
        check("t5_dp_a", dp_a, 2'b11);
        a_bus[5:4] = 2'b00; b_bus[5:4] = 2'b00;
        req = 4'b0;
        tick();
        check("t5_dp_a_hold", dp_a, 2'b11);
        check("t5_dp_b_hold", dp_b, 2'b11);
        wait_done(1'b0);
        check("t5_result", result, 2'b01);
        check("t5_done_id", done_id, 2);

        // LAT=1 instance
        a_bus1[1:0] = 2'b10; b_bus1[1:0] = 2'b11;
        req1 = 4'b0001;
        tick();
        check("t6_gnt", gnt1, 4'b0001);
        req1 = 4'b0;
        tick();
        check("t6_done_early", done1, 0);
        tick();
        check("t6_done", done1, 1);
        check("t6_result", result1, 2'b10);
        check("t6_done_id", done_id1, 0);
        tick();
        check("t6_done_low", done1, 0);
        req1 = 4'b1111;
        wait_gnt(1'b1, id, cyc);
        check("t6_first", id, 1);
        wait_gnt(1'b1, id, cyc);
        check("t6_second", id, 2);
        check("t6_period", cyc, 4);
        req1 = 4'b0;
        wait_done(1'b1);

        check("gnt_done_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
